// File: rtl/isp_pkg.sv
// isp_pkg: shared types and constants for the ISP frame-buffer blocks.
//   - Default active resolution (1920x1080).
//   - RGB565 field positions (R 15:11, G 10:5, B 4:0).
//   - fb_rd_state_t: frame reader FSM states.
//   - rgb565_to_888: bit-replicating expansion to RGB888.
package isp_pkg;

    localparam int unsigned DEF_H_ACTIVE = 1920;
    localparam int unsigned DEF_V_ACTIVE = 1080;

    localparam int unsigned RGB565_R_MSB = 15;
    localparam int unsigned RGB565_R_LSB = 11;
    localparam int unsigned RGB565_G_MSB = 10;
    localparam int unsigned RGB565_G_LSB = 5;
    localparam int unsigned RGB565_B_MSB = 4;
    localparam int unsigned RGB565_B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fb_rd_state_t;

    // Replicate the top bits of each field into the new LSBs so that full
    // scale maps to 8'hFF and zero stays zero.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = {d[RGB565_R_MSB:RGB565_R_LSB], d[RGB565_R_MSB -: 3]};
        g = {d[RGB565_G_MSB:RGB565_G_LSB], d[RGB565_G_MSB -: 2]};
        b = {d[RGB565_B_MSB:RGB565_B_LSB], d[RGB565_B_MSB -: 3]};
        return {r, g, b};
    endfunction

endpackage

// File: rtl/fb_rd_fifo.sv
// fb_rd_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     write strobe and data; a push while full is dropped
//   pop             read strobe; ignored while empty
//   rdata           head entry (zero while empty)
//   empty, full     status flags
//   cnt             number of stored entries (0..DEPTH)
module fb_rd_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign cnt     = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fb_reader.sv
// fb_reader: frame-buffer read engine. Fetches H_ACTIVE*V_ACTIVE RGB565
// pixels from BASE_ADDR upward over a split request/return read port,
// buffers them, and streams them out with frame/line markers.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       frame start pulse (honoured in IDLE only)
//   busy                        high while fetching or draining
//   rd_req/rd_addr/rd_gnt       read request channel
//   rd_rvalid/rd_rdata          in-order read return channel
//   pix_valid/pix_rdy/pix_data  pixel stream (FWFT)
//   pix_r/pix_g/pix_b           RGB888 expansion of pix_data
//   pix_sof/pix_eol/pix_eof     markers, qualified by pix_valid
//   frame_done                  one-cycle pulse after the last pixel pops
//   ovf_err                     sticky: return arrived with FIFO full
module fb_reader
    import isp_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_gnt,
    input  logic        rd_rvalid,
    input  logic [15:0] rd_rdata,
    output logic        pix_valid,
    input  logic        pix_rdy,
    output logic [15:0] pix_data,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        frame_done,
    output logic        ovf_err
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(H_ACTIVE * V_ACTIVE) - 32'd1;

    fb_rd_state_t  state_q;
    logic [31:0]   rd_addr_q;
    logic [CW-1:0] outstanding_q;
    logic [11:0]   h_cnt_q;
    logic [11:0]   v_cnt_q;
    logic          frame_done_q;
    logic          ovf_err_q;

    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW:0]   inflight;
    logic          grant;
    logic          pop;
    logic          h_last;
    logic          v_last;

    // Credit: never request more than the FIFO can absorb, counting data
    // already stored plus data still on its way back.
    assign inflight = {1'b0, fifo_cnt} + {1'b0, outstanding_q};
    assign rd_req   = (state_q == FETCH) && (inflight < (CW+1)'(FIFO_DEPTH));
    assign rd_addr  = rd_addr_q;
    assign grant    = rd_req && rd_gnt;
    assign busy     = (state_q != IDLE);

    assign pix_valid = !fifo_empty;
    assign pop       = pix_valid && pix_rdy;
    assign h_last    = (h_cnt_q == 12'(H_ACTIVE - 1));
    assign v_last    = (v_cnt_q == 12'(V_ACTIVE - 1));
    assign pix_sof   = pix_valid && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign pix_eol   = pix_valid && h_last;
    assign pix_eof   = pix_eol && v_last;

    assign {pix_r, pix_g, pix_b} = rgb565_to_888(pix_data);
    assign frame_done = frame_done_q;
    assign ovf_err    = ovf_err_q;

    fb_rd_fifo #(
        .WIDTH(16),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (rd_rvalid),
        .wdata(rd_rdata),
        .pop  (pop),
        .rdata(pix_data),
        .empty(fifo_empty),
        .full (fifo_full),
        .cnt  (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_addr_q     <= BASE_ADDR;
            outstanding_q <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_done_q  <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            unique case ({grant, rd_rvalid})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            if (rd_rvalid && fifo_full) begin
                ovf_err_q <= 1'b1;
            end

            if (pop) begin
                if (h_last) begin
                    h_cnt_q <= '0;
                    v_cnt_q <= v_last ? '0 : v_cnt_q + 12'd1;
                end else begin
                    h_cnt_q <= h_cnt_q + 12'd1;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= FETCH;
                        rd_addr_q <= BASE_ADDR;
                        h_cnt_q   <= '0;
                        v_cnt_q   <= '0;
                        ovf_err_q <= 1'b0;
                    end
                end
                FETCH: begin
                    // Hold the last address rather than running past the frame.
                    if (grant) begin
                        if (rd_addr_q == LAST_ADDR) begin
                            state_q <= DRAIN;
                        end else begin
                            rd_addr_q <= rd_addr_q + 32'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && pix_eof) begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_reader.sv
module tb_fb_reader;

    localparam int unsigned H     = 4;
    localparam int unsigned V     = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NPIX  = H * V;
    localparam logic [31:0] BASE  = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic        rd_rvalid;
    logic [15:0] rd_rdata;
    logic        pix_valid;
    logic        pix_rdy;
    logic [15:0] pix_data;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic        frame_done;
    logic        ovf_err;

    fb_reader #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .pix_valid (pix_valid),
        .pix_rdy   (pix_rdy),
        .pix_data  (pix_data),
        .pix_r     (pix_r),
        .pix_g     (pix_g),
        .pix_b     (pix_b),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .pix_eof   (pix_eof),
        .frame_done(frame_done),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        bit          sof;
        bit          eol;
        bit          eof;
    } exp_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    exp_t        exp_q[$];
    ret_t        ret_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          grant_cnt = 0;
    int          last_due = 0;
    logic [31:0] exp_addr = BASE;
    int          gnt_mode = 0;  // 0 always, 1 toggle, 2 random
    int          rdy_mode = 0;  // 0 always, 1 never, 2 random
    int          data_mode = 0; // 0 address, 1 random, 2 colour patterns
    int          lat_min = 2;
    int          lat_max = 2;
    bit          done_due = 0;
    logic [15:0] pat [4] = '{16'hF800, 16'h07E0, 16'h0841, 16'hFFFF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expand an n-bit channel to 8 bits by scaling up and refilling the low
    // bits from the top of the field.
    function automatic logic [7:0] exp5(input int v);
        return 8'(v * 8 + v / 4);
    endfunction

    function automatic logic [7:0] exp6(input int v);
        return 8'(v * 4 + v / 16);
    endfunction

    // Memory side: grants, in-order returns with bounded random latency, sink ready.
    initial begin : mem_model
        bit          held;
        logic [31:0] held_addr;
        held = 0;
        held_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (!rst_n) begin
                ret_q.delete();
                rd_rvalid = 1'b0;
                rd_gnt = 1'b0;
                held = 0;
                continue;
            end
            case (gnt_mode)
                0:       rd_gnt = 1'b1;
                1:       rd_gnt = cycle[0];
                default: rd_gnt = 1'($urandom_range(1, 0));
            endcase
            case (rdy_mode)
                0:       pix_rdy = 1'b1;
                1:       pix_rdy = 1'b0;
                default: pix_rdy = 1'($urandom_range(1, 0));
            endcase
            if (ret_q.size() > 0 && ret_q[0].due <= cycle) begin
                rd_rvalid = 1'b1;
                rd_rdata = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                rd_rvalid = 1'b0;
                rd_rdata = 16'($urandom);
            end
            @(negedge clk);
            if (held && rd_req) chk("addr_stable", rd_addr, held_addr);
            held = rd_req && !rd_gnt;
            held_addr = rd_addr;
            if (rd_req && rd_gnt) begin
                exp_t e;
                ret_t r;
                int   d;
                chk("grant_addr", rd_addr, exp_addr);
                case (data_mode)
                    0:       e.data = exp_addr[15:0];
                    1:       e.data = 16'($urandom);
                    default: e.data = pat[grant_cnt % 4];
                endcase
                e.sof = (grant_cnt == 0);
                e.eol = ((grant_cnt % H) == H - 1);
                e.eof = (grant_cnt == NPIX - 1);
                exp_q.push_back(e);
                d = cycle + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                r.due = d;
                r.data = e.data;
                ret_q.push_back(r);
                grant_cnt++;
                exp_addr++;
            end
        end
    end

    // Output monitor: pops the scoreboard on every accepted pixel.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_due = 0;
                continue;
            end
            if (done_due) begin
                chk("frame_done", 32'(frame_done), 32'(1));
                chk("busy_after_done", 32'(busy), 32'(0));
                done_due = 0;
            end else if (frame_done) begin
                chk("frame_done_spurious", 32'(frame_done), 32'(0));
            end
            if (pix_valid && pix_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got %0h expected none at %0t", pix_data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pix_data", 32'(pix_data), 32'(e.data));
                    chk("pix_r", 32'(pix_r), 32'(exp5(int'(e.data[15:11]))));
                    chk("pix_g", 32'(pix_g), 32'(exp6(int'(e.data[10:5]))));
                    chk("pix_b", 32'(pix_b), 32'(exp5(int'(e.data[4:0]))));
                    chk("pix_sof", 32'(pix_sof), 32'(e.sof));
                    chk("pix_eol", 32'(pix_eol), 32'(e.eol));
                    chk("pix_eof", 32'(pix_eof), 32'(e.eof));
                    if (e.eof) done_due = 1;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_req"}, 32'(rd_req), 32'(0));
        chk({tag, "_rd_addr"}, rd_addr, BASE);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'(0));
        chk({tag, "_pix_data"}, 32'(pix_data), 32'(0));
        chk({tag, "_markers"}, 32'({pix_sof, pix_eol, pix_eof}), 32'(0));
        chk({tag, "_rgb"}, 32'({pix_r, pix_g, pix_b}), 32'(0));
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
        chk({tag, "_ovf_err"}, 32'(ovf_err), 32'(0));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic start_frame();
        exp_addr = BASE;
        grant_cnt = 0;
        pulse_start();
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'(1));
        chk("start_rd_req", 32'(rd_req), 32'(1));
        chk("start_rd_addr", rd_addr, BASE);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!frame_done && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done expected one within 600 cycles");
        end
        chk("grant_count", 32'(grant_cnt), 32'(NPIX));
        chk("ovf_err", 32'(ovf_err), 32'(0));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        repeat (3) @(negedge clk);
        chk("idle_rd_req", 32'(rd_req), 32'(0));
    endtask

    task automatic run_frame(input bit restart);
        start_frame();
        if (restart) begin
            repeat (2) @(posedge clk);
            pulse_start();
        end
        wait_done();
    endtask

    initial begin : main
        rst_n = 1'b0;
        start = 1'b0;
        rd_gnt = 1'b0;
        rd_rvalid = 1'b0;
        rd_rdata = '0;
        pix_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: always granted, fixed 2-cycle latency, data = address.
        gnt_mode = 0; rdy_mode = 0; data_mode = 0; lat_min = 2; lat_max = 2;
        run_frame(0);

        // Sink stalled: credit must stop requests at the FIFO depth.
        rdy_mode = 1;
        start_frame();
        repeat (30) @(negedge clk);
        chk("stall_grants", 32'(grant_cnt), 32'(DEPTH));
        chk("stall_rd_req", 32'(rd_req), 32'(0));
        chk("stall_ovf", 32'(ovf_err), 32'(0));
        rdy_mode = 0;
        wait_done();

        // Toggling grant, random latency and data.
        gnt_mode = 1; data_mode = 1; lat_min = 1; lat_max = 3;
        run_frame(0);

        // Colour patterns for the RGB888 expansion.
        gnt_mode = 0; data_mode = 2; lat_min = 2; lat_max = 2;
        run_frame(0);

        // Second start during FETCH must be ignored.
        data_mode = 0;
        run_frame(1);

        // Fully random traffic.
        for (int i = 0; i < 4; i++) begin
            gnt_mode = 2; rdy_mode = 2; data_mode = 1; lat_min = 1; lat_max = 5;
            run_frame(0);
        end

        // Reset in the middle of a frame, then a clean frame.
        gnt_mode = 0; rdy_mode = 2; data_mode = 0; lat_min = 2; lat_max = 3;
        start_frame();
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        run_frame(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
